// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder built from one full-adder cell and a
// carry flip-flop. Operands are captured on an accepted start and consumed LSB
// first, one bit per clock; a one-cycle done pulse marks a valid sum/cout.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   start  request, sampled only in IDLE or DONE
//   a, b   WIDTH-bit addends, captured on accepted start
//   cin    carry-in, captured on accepted start
//   busy   high while a sum is in progress
//   done   one-cycle pulse, sum/cout valid
//   sum    (a+b+cin) mod 2^WIDTH, held until the next completion
//   cout   carry out of bit WIDTH-1
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             carry_ff;
  logic [CW-1:0]    cnt;

  // Full-adder cell on the current LSBs.
  logic             fa_s;
  logic             fa_c;
  logic [WIDTH-1:0] res_next;

  always_comb begin
    fa_s     = a_sh[0] ^ b_sh[0] ^ carry_ff;
    fa_c     = (a_sh[0] & b_sh[0]) | (carry_ff & (a_sh[0] ^ b_sh[0]));
    res_next = {fa_s, res_sh[WIDTH-1:1]};
  end

  // Control FSM and datapath registers; every output is a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      carry_ff <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          // DONE accepts start exactly like IDLE, enabling back-to-back ops.
          if (start) begin
            a_sh     <= a;
            b_sh     <= b;
            carry_ff <= cin;
            res_sh   <= '0;
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          // start is deliberately not looked at here.
          carry_ff <= fa_c;
          res_sh   <= res_next;
          a_sh     <= a_sh >> 1;
          b_sh     <= b_sh >> 1;
          cnt      <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            sum   <= res_next;
            cout  <= fa_c;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         cyc = 0;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       cin8 = 1'b0;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       cin4 = 1'b0;
  logic       busy4, done4, cout4;
  logic [3:0] sum4;

  typedef struct {
    int res;
    int e0;
  } exp_t;

  exp_t q8[$];
  exp_t q4[$];

  int n_vec = 0;
  int n_err = 0;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard pop on each done pulse: value and latency.
  always @(negedge clk) begin
    if (!rst && done8) begin
      chk("busy8_with_done", int'(busy8), 0);
      if (q8.size() == 0) chk("spurious_done8", 1, 0);
      else begin
        exp_t e;
        e = q8.pop_front();
        chk("sum8", int'({cout8, sum8}), e.res);
        chk("lat8", cyc - e.e0, 8);
      end
    end
    if (!rst && done4) begin
      if (q4.size() == 0) chk("spurious_done4", 1, 0);
      else begin
        exp_t e;
        e = q4.pop_front();
        chk("sum4", int'({cout4, sum4}), e.res);
        chk("lat4", cyc - e.e0, 4);
      end
    end
  end

  // Pulse start for one cycle; returns at the negedge after the capture edge.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c);
    @(negedge clk);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    q8.push_back('{int'(a) + int'(b) + int'(c), cyc + 1});
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic c);
    @(negedge clk);
    a4 = a; b4 = b; cin4 = c; start4 = 1'b1;
    q4.push_back('{int'(a) + int'(b) + int'(c), cyc + 1});
    @(negedge clk);
    start4 = 1'b0;
  endtask

  task automatic drain8(input int max);
    for (int i = 0; i < max && q8.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (q8.size() != 0) begin
      chk("timeout8", q8.size(), 0);
      q8.delete();
    end
  endtask

  task automatic drain4(input int max);
    for (int i = 0; i < max && q4.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (q4.size() != 0) begin
      chk("timeout4", q4.size(), 0);
      q4.delete();
    end
  endtask

  initial begin
    int e0;
    int k;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy8), 0);
    chk("rst_done", int'(done8), 0);
    chk("rst_sum", int'(sum8), 0);
    chk("rst_cout", int'(cout8), 0);
    chk("rst_busy4", int'(busy4), 0);
    rst = 1'b0;

    // Basic add with busy profile
    issue8(8'h5A, 8'h3C, 1'b0);
    e0 = cyc;
    for (k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk($sformatf("busy_k%0d", k), int'(busy8), (k <= 7) ? 1 : 0);
    end
    drain8(5);
    chk("hold_idle_sum", int'(sum8), 'h96);

    // Carry boundaries; sum must hold through the next RUN
    issue8(8'hFF, 8'h01, 1'b0);
    repeat (3) @(negedge clk);
    chk("hold_run_sum", int'(sum8), 'h96);
    drain8(20);
    issue8(8'hFF, 8'hFF, 1'b1);
    drain8(20);
    issue8(8'h00, 8'h00, 1'b1);
    drain8(20);

    // start during RUN is ignored, input changes after capture are ignored
    issue8(8'h10, 8'h20, 1'b0);
    for (k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 2) begin
        a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
      end else if (k == 3) begin
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'b1;
      end
      chk($sformatf("ign_busy_k%0d", k), int'(busy8), (k <= 7) ? 1 : 0);
    end
    drain8(5);

    // start held high: back-to-back on each DONE cycle
    @(negedge clk);
    a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    e0 = cyc + 1;
    q8.push_back('{2, e0});
    q8.push_back('{2, e0 + 9});
    q8.push_back('{2, e0 + 18});
    @(negedge clk);
    do begin
      @(negedge clk);
      k = cyc - e0;
      if (k == 18) start8 = 1'b0;
      chk($sformatf("held_busy_k%0d", k), int'(busy8),
          (k == 8 || k == 17 || k == 26) ? 0 : 1);
    end while (k < 26);
    drain8(5);

    // Reset mid-RUN aborts and clears the result
    issue8(8'h5A, 8'h3C, 1'b0);
    drain8(20);
    issue8(8'hF0, 8'h0F, 1'b0);
    repeat (3) @(negedge clk);
    chk("pre_rst_sum", int'(sum8), 'h96);
    rst = 1'b1;
    q8.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", int'(busy8), 0);
    chk("abort_done", int'(done8), 0);
    chk("abort_sum", int'(sum8), 0);
    chk("abort_cout", int'(cout8), 0);
    issue8(8'h12, 8'h34, 1'b1);
    drain8(20);

    // Exhaustive WIDTH=4 sweep
    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        for (int ic = 0; ic < 2; ic++) begin
          issue4(4'(ia), 4'(ib), 1'(ic));
          drain4(12);
        end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
